// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// loader_pkg : states and widths shared by the program loader, program RAM
//              and CPU.
// Revision   : 1.0
// ============================================================================
package loader_pkg;

    localparam int          C_PM_ADDR_W  = 11;
    localparam int          C_PM_DATA_W  = 14;
    localparam int          C_MAX_WORDS  = 2048;
    localparam logic [7:0]  C_SYNC_BYTE  = 8'hA5;
    // Width of the word count carried in the frame header.
    localparam int          C_CNT_W      = 11;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CNT_H = 4'd1,
        ST_CNT_L = 4'd2,
        ST_DAT_L = 4'd3,
        ST_DAT_H = 4'd4,
        ST_WRITE = 4'd5,
        ST_CHK   = 4'd6,
        ST_DONE  = 4'd7,
        ST_ERR   = 4'd8
    } state_e;

    // The byte source is stalled only while a word is written or a frame closes.
    function automatic logic accepts_bytes(input state_e s);
        return !(s inside {ST_WRITE, ST_DONE, ST_ERR});
    endfunction

endpackage

`default_nettype wire

// File: rtl/prog_mem_loader.sv
`default_nettype none
// ============================================================================
// prog_mem_loader : assembles 14-bit instruction words from a framed byte
//                   stream and writes them into program RAM from address 0.
// Revision        : 1.0
// ============================================================================
module prog_mem_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W    = C_PM_ADDR_W,
    parameter int         DATA_W    = C_PM_DATA_W,
    parameter logic [7:0] SYNC_BYTE = C_SYNC_BYTE,
    parameter int         MAX_WORDS = C_MAX_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [DATA_W-1:0] pm_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e              state_q, state_d;
    logic [7:0]          cnt_hi_q, cnt_hi_d;
    logic [C_CNT_W-1:0]  n_q, n_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [7:0]          lo_q, lo_d;
    logic [7:0]          sum_q, sum_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                hold_q, hold_d;
    logic                err_q, err_d;
    logic                ready_q, ready_d;
    logic                we_q, we_d;
    logic                done_q, done_d;

    logic                acc;
    logic [C_CNT_W-1:0]  n_w;
    logic [7:0]          sum_w;

    assign acc   = rx_valid && ready_q;
    assign n_w   = {cnt_hi_q[2:0], rx_data};
    assign sum_w = sum_q + rx_data;

    always_comb begin
        state_d  = state_q;
        cnt_hi_d = cnt_hi_q;
        n_d      = n_q;
        idx_d    = idx_q;
        lo_d     = lo_q;
        sum_d    = sum_q;
        wdata_d  = wdata_q;
        hold_d   = hold_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (acc && rx_data == SYNC_BYTE) begin
                    state_d = ST_CNT_H;
                    hold_d  = 1'b1;
                    err_d   = 1'b0;
                    sum_d   = 8'h00;
                    idx_d   = '0;
                end
            end
            ST_CNT_H: begin
                if (acc) begin
                    cnt_hi_d = rx_data;
                    sum_d    = sum_w;
                    state_d  = ST_CNT_L;
                end
            end
            ST_CNT_L: begin
                if (acc) begin
                    n_d   = n_w;
                    sum_d = sum_w;
                    if (cnt_hi_q[7:3] != 5'd0 || int'(n_w) > MAX_WORDS)
                        state_d = ST_ERR;
                    else if (n_w == '0)
                        state_d = ST_CHK;
                    else
                        state_d = ST_DAT_L;
                end
            end
            ST_DAT_L: begin
                if (acc) begin
                    lo_d    = rx_data;
                    sum_d   = sum_w;
                    state_d = ST_DAT_H;
                end
            end
            ST_DAT_H: begin
                if (acc) begin
                    sum_d = sum_w;
                    if (rx_data[7:6] != 2'b00) begin
                        state_d = ST_ERR;
                    end else begin
                        wdata_d = DATA_W'({rx_data[5:0], lo_q});
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                idx_d   = idx_q + ADDR_W'(1);
                state_d = (int'(idx_q) + 1 == int'(n_q)) ? ST_CHK : ST_DAT_L;
            end
            ST_CHK: begin
                if (acc)
                    state_d = (sum_w == 8'h00) ? ST_DONE : ST_ERR;
            end
            ST_DONE: begin
                hold_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                // cpu_hold stays set so a partial image is never executed.
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so reset forces them low.
    assign we_d    = (state_d == ST_WRITE);
    assign done_d  = (state_d == ST_DONE);
    assign ready_d = accepts_bytes(state_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_hi_q <= 8'h00;
            n_q      <= '0;
            idx_q    <= '0;
            lo_q     <= 8'h00;
            sum_q    <= 8'h00;
            wdata_q  <= '0;
            hold_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_hi_q <= cnt_hi_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            lo_q     <= lo_d;
            sum_q    <= sum_d;
            wdata_q  <= wdata_d;
            hold_q   <= hold_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            we_q     <= we_d;
            done_q   <= done_d;
        end
    end

    assign rx_ready = ready_q;
    assign pm_we    = we_q;
    assign pm_addr  = idx_q;
    assign pm_wdata = wdata_q;
    assign cpu_hold = hold_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign err      = err_q;

endmodule

`default_nettype wire
